// File: rtl/vi_bin_to_onehot_pipe.sv
// Binary-to-one-hot decoder behind a two-entry skid buffer, with a saturating
// counter of out-of-range codes delivered downstream.
module vi_bin_to_onehot_pipe #(
    parameter int ONEHOT_WIDTH = 16,
    parameter int BIN_WIDTH    = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_WIDTH-1:0]    in_bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ONEHOT_WIDTH-1:0] out_onehot,
    output logic                    out_err,
    input  logic                    err_clr,
    output logic [CNT_WIDTH-1:0]    err_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [ONEHOT_WIDTH-1:0] decode_onehot(input logic [BIN_WIDTH-1:0] bin);
        logic [ONEHOT_WIDTH-1:0] oh;
        oh = '0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            oh[i] = (32'(bin) == 32'(i));
        end
        return oh;
    endfunction

    function automatic logic range_err(input logic [BIN_WIDTH-1:0] bin);
        return (32'(bin) >= 32'(ONEHOT_WIDTH));
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);
    endfunction

    // p0 is the word presented downstream, p1 the skid slot behind it
    logic                    vld_p0, vld_p1;
    logic                    in_ready_r;
    logic [ONEHOT_WIDTH-1:0] onehot_p0, onehot_p1;
    logic                    err_p0, err_p1;
    logic [CNT_WIDTH-1:0]    err_cnt_r;

    logic                    acc, dlv;
    logic                    head_load_new, head_load_tail, tail_load;
    logic [ONEHOT_WIDTH-1:0] new_onehot;
    logic                    new_err;

    assign acc            = in_valid && in_ready_r;
    assign dlv            = vld_p0 && out_ready;
    assign new_onehot     = decode_onehot(in_bin);
    assign new_err        = range_err(in_bin);
    assign head_load_tail = vld_p1 && dlv;
    assign head_load_new  = acc && !vld_p1 && (!vld_p0 || dlv);
    assign tail_load      = acc && vld_p0 && !dlv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            in_ready_r <= 1'b0;
        end else if (vld_p1) begin
            // full: only a delivery can free the skid slot
            if (dlv) begin
                vld_p1     <= 1'b0;
                in_ready_r <= 1'b1;
            end else begin
                in_ready_r <= 1'b0;
            end
        end else if (vld_p0) begin
            if (acc && !dlv) begin
                vld_p1     <= 1'b1;
                in_ready_r <= 1'b0;
            end else begin
                if (dlv && !acc) begin
                    vld_p0 <= 1'b0;
                end
                in_ready_r <= 1'b1;
            end
        end else begin
            vld_p0     <= acc;
            in_ready_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (head_load_tail) begin
            onehot_p0 <= onehot_p1;
            err_p0    <= err_p1;
        end else if (head_load_new) begin
            onehot_p0 <= new_onehot;
            err_p0    <= new_err;
        end
        if (tail_load) begin
            onehot_p1 <= new_onehot;
            err_p1    <= new_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= '0;
        end else if (err_clr) begin
            err_cnt_r <= '0;
        end else if (dlv && err_p0) begin
            err_cnt_r <= sat_inc(err_cnt_r);
        end
    end

    // data registers are not reset, so the presented word is gated by its valid
    assign in_ready   = in_ready_r;
    assign out_valid  = vld_p0;
    assign out_onehot = vld_p0 ? onehot_p0 : '0;
    assign out_err    = vld_p0 ? err_p0 : 1'b0;
    assign err_cnt    = err_cnt_r;

endmodule

// File: doc/vi_bin_to_onehot_pipe.md
VI_BIN_TO_ONEHOT_PIPE -- requirements
Module: vi_bin_to_onehot_pipe

Interface
REQ-001 SHALL have parameter ONEHOT_WIDTH, default 16: number of one-hot output lines.
REQ-002 SHALL have parameter BIN_WIDTH, default 4: binary code width, always >= ceil(log2(ONEHOT_WIDTH)).
REQ-003 SHALL have parameter CNT_WIDTH, default 8: width of the error counter.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: in_bin carries a code.
REQ-007 SHALL have port in_ready, output, 1: block can accept a code this cycle.
REQ-008 SHALL have port in_bin, input, BIN_WIDTH: binary code to decode.
REQ-009 SHALL have port out_valid, output, 1: out_onehot/out_err hold a decoded word.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the word.
REQ-011 SHALL have port out_onehot, output, ONEHOT_WIDTH: decoded one-hot vector.
REQ-012 SHALL have port out_err, output, 1: set when the word's code was out of range.
REQ-013 SHALL have port err_clr, input, 1: synchronous clear of err_cnt.
REQ-014 SHALL have port err_cnt, output, CNT_WIDTH: saturating count of out-of-range words delivered.

Function
REQ-015 SHALL accept an input word on a rising edge where in_valid && in_ready; SHALL deliver an output word on a rising edge where out_valid && out_ready.
REQ-016 SHALL decode a code b < ONEHOT_WIDTH as out_onehot bit b = 1, all other bits 0, out_err = 0.
REQ-017 SHALL decode a code b >= ONEHOT_WIDTH as out_onehot = all zeros, out_err = 1.
REQ-018 SHALL register the decoded word: a word accepted at edge N SHALL be presented, with out_valid = 1, from edge N+1 onward (1-cycle latency, empty pipe).
REQ-019 SHALL buffer up to 2 decoded words (skid buffer), preserving order, with no loss or duplication.
REQ-020 SHALL drive in_ready from a register: 1 when fewer than 2 words are held, 0 when 2 are held; in_ready SHALL NOT depend combinationally on out_ready.
REQ-021 SHALL hold out_onehot and out_err stable while out_valid && !out_ready.
REQ-022 SHALL, with 1 word held and simultaneous accept and deliver, keep occupancy at 1 and present the new word on the next cycle.
REQ-023 SHALL, with 2 words held and out_ready = 1, deliver the older word, present the second, and raise in_ready on the following cycle.
REQ-024 SHALL ignore in_bin when in_valid = 0 or in_ready = 0.
REQ-025 SHALL increment err_cnt by 1 on each delivery of a word with out_err = 1, saturating at 2^CNT_WIDTH-1.
REQ-026 SHALL, when err_clr = 1, set err_cnt to 0 at the next edge; clear SHALL win over a same-cycle increment.
REQ-027 SHALL drive out_onehot and out_err to 0 whenever out_valid = 0.

Reset
REQ-028 SHALL, while rst_n = 0, force out_valid = 0, in_ready = 0, out_onehot = 0, out_err = 0, err_cnt = 0, occupancy = 0, independent of clk.
REQ-029 SHALL raise in_ready on the first rising edge after rst_n deasserts.
REQ-030 SHALL discard all buffered words on reset mid-operation; none SHALL be delivered after reset.

Verification
REQ-031 Single word: ONEHOT_WIDTH=16, in_bin=5 accepted at edge N, out_ready=1 -> out_valid=1 and out_onehot=0x0020 after edge N+1, out_err=0.
REQ-032 Out of range: ONEHOT_WIDTH=12, BIN_WIDTH=4, in_bin=13 delivered -> out_onehot=0x000, out_err=1, err_cnt 0->1.
REQ-033 Backpressure: out_ready=0, push 3,7,9 back-to-back -> in_ready=0 after 2 accepts, 9 held off; release out_ready -> outputs 0x0008, 0x0080, 0x0200 in order, no gaps once streaming.
REQ-034 Full throughput: in_valid=out_ready=1 for codes 0..15 -> 16 words on 16 consecutive cycles, each with only the matching bit set.
REQ-035 Saturation/clear: CNT_WIDTH=2, deliver 5 out-of-range words -> err_cnt=3; err_clr during a 6th error delivery -> err_cnt=0.
REQ-036 Reset mid-stream: 2 words buffered, rst_n pulsed low asynchronously -> out_valid=0 immediately, no buffered word appears after release, in_ready=1 one edge after release.
